// File: rtl/mmio_responder.sv
// mmio_responder: 16-word MMIO window on the processor data port providing a
// free-running cycle counter with compare/interrupt and an output FIFO that an
// external consumer drains through a valid/ready handshake.
module mmio_responder #(
   parameter logic [15:0] BASE_ADDR  = 16'hFF00,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] DataAdr,
   input  logic [15:0] writeData,
   input  logic        memwrite,
   output logic [15:0] readData,
   output logic        sel,
   output logic        out_valid,
   output logic [15:0] out_data,
   input  logic        out_ready,
   output logic        irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [15:0] cycle_q, cycle_d;
   logic [15:0] cmp_q, cmp_d;
   logic        en_q, en_d, ie_q, ie_d;
   logic        match_q, match_d, ovf_q, ovf_d, irq_q;
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [15:0] mem_q [FIFO_DEPTH];

   logic [3:0] off;
   logic       wr_en, wr_cycle, wr_cmp, wr_tx, wr_stat, wr_ctrl;
   logic       full, empty, pop, push_acc, match_set;
   logic [15:0] status;

   assign off      = DataAdr[3:0];
   assign sel      = (DataAdr[15:4] == BASE_ADDR[15:4]);
   assign wr_en    = memwrite & sel;
   assign wr_cycle = wr_en & (off == 4'h0);
   assign wr_cmp   = wr_en & (off == 4'h1);
   assign wr_tx    = wr_en & (off == 4'h2);
   assign wr_stat  = wr_en & (off == 4'h3);
   assign wr_ctrl  = wr_en & (off == 4'h4);

   assign full      = (cnt_q == CW'(FIFO_DEPTH));
   assign empty     = (cnt_q == '0);
   assign pop       = ~empty & out_ready;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push_acc  = wr_tx & (~full | pop);
   assign match_set = en_q & (cycle_q == cmp_q);

   // Count field is 4 bits wide; at depth 16 a full FIFO wraps it to 0.
   assign status    = {8'h00, match_q, ovf_q, full, empty, 4'(cnt_q)};

   assign out_valid = ~empty;
   assign out_data  = empty ? 16'h0000 : mem_q[rptr_q];
   assign irq       = irq_q;

   // Next-state for counter, config, sticky flags and FIFO bookkeeping.
   always_comb begin
      cycle_d = cycle_q;
      if (wr_cycle)  cycle_d = writeData;
      else if (en_q) cycle_d = cycle_q + 16'd1;
      cmp_d = wr_cmp ? writeData : cmp_q;
      en_d  = wr_ctrl ? writeData[0] : en_q;
      ie_d  = wr_ctrl ? writeData[1] : ie_q;
      // Sticky flags: a set in the same cycle as a W1C clear wins.
      match_d = match_set | (match_q & ~(wr_stat & writeData[7]));
      ovf_d   = (wr_tx & full & ~pop) | (ovf_q & ~(wr_stat & writeData[6]));
      wptr_d  = push_acc ? wptr_q + AW'(1) : wptr_q;
      rptr_d  = pop ? rptr_q + AW'(1) : rptr_q;
      cnt_d   = cnt_q;
      case ({push_acc, pop})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   // State registers; reset clears everything without waiting for a clock.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cycle_q <= 16'h0000;
         cmp_q   <= 16'hFFFF;
         en_q    <= 1'b0;
         ie_q    <= 1'b0;
         match_q <= 1'b0;
         ovf_q   <= 1'b0;
         irq_q   <= 1'b0;
         wptr_q  <= '0;
         rptr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         cycle_q <= cycle_d;
         cmp_q   <= cmp_d;
         en_q    <= en_d;
         ie_q    <= ie_d;
         match_q <= match_d;
         ovf_q   <= ovf_d;
         irq_q   <= match_q & ie_q;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         cnt_q   <= cnt_d;
      end
   end

   // FIFO storage; contents are don't-care while the count says empty.
   always_ff @(posedge clk) begin
      if (push_acc) mem_q[wptr_q] <= writeData;
   end

   // Combinational register read mux, zero when outside the window.
   always_comb begin
      readData = 16'h0000;
      if (sel) begin
         case (off)
            4'h0:    readData = cycle_q;
            4'h1:    readData = cmp_q;
            4'h3:    readData = status;
            4'h4:    readData = {14'h0000, ie_q, en_q};
            default: readData = 16'h0000;
         endcase
      end
   end

endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: directed walk through the register map plus a
// randomized phase, all checked against a queue-based reference model.
module tb_mmio_responder;

   localparam logic [15:0] BASE    = 16'hFF00;
   localparam logic [11:0] BASE_HI = 12'hFF0;
   localparam int          DEPTH   = 8;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] DataAdr, writeData, readData, out_data;
   logic        memwrite, sel, out_valid, out_ready, irq;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   logic [15:0] m_cyc, m_cmp;
   logic        m_en, m_ie, m_match, m_ovf, m_irq;
   logic [15:0] m_q[$];

   always #5 clk = ~clk;

   mmio_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .DataAdr(DataAdr), .writeData(writeData),
      .memwrite(memwrite), .readData(readData), .sel(sel),
      .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
      .irq(irq)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cyc = 16'h0000; m_cmp = 16'hFFFF;
      m_en = 1'b0; m_ie = 1'b0; m_match = 1'b0; m_ovf = 1'b0; m_irq = 1'b0;
      m_q.delete();
   endtask

   function automatic logic [15:0] m_rd(input logic [15:0] a);
      logic [15:0] s;
      int          sz;
      sz = m_q.size();
      s  = 16'h0000;
      if (a[15:4] != BASE_HI) return 16'h0000;
      case (a[3:0])
         4'h0: return m_cyc;
         4'h1: return m_cmp;
         4'h3: begin
            s[7]   = m_match;
            s[6]   = m_ovf;
            s[5]   = (sz == DEPTH);
            s[4]   = (sz == 0);
            s[3:0] = 4'(sz);
            return s;
         end
         4'h4: return {14'h0000, m_ie, m_en};
         default: return 16'h0000;
      endcase
   endfunction

   // Advance the model by one rising edge using the inputs now applied.
   task automatic model_step();
      logic       w, pop, push, mset;
      logic [3:0] o;
      int         sz;
      w    = memwrite && (DataAdr[15:4] == BASE_HI);
      o    = DataAdr[3:0];
      sz   = m_q.size();
      pop  = (sz > 0) && out_ready;
      push = w && (o == 4'h2);
      mset = m_en && (m_cyc == m_cmp);
      m_irq   = m_match && m_ie;
      m_match = mset || (m_match && !(w && o == 4'h3 && writeData[7]));
      m_ovf   = (push && sz == DEPTH && !pop) || (m_ovf && !(w && o == 4'h3 && writeData[6]));
      if (w && o == 4'h0) m_cyc = writeData;
      else if (m_en)      m_cyc = m_cyc + 16'd1;
      if (w && o == 4'h1) m_cmp = writeData;
      if (w && o == 4'h4) begin m_en = writeData[0]; m_ie = writeData[1]; end
      if (pop) void'(m_q.pop_front());
      if (push && (sz < DEPTH || pop)) m_q.push_back(writeData);
   endtask

   task automatic cyc();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] o, input logic [15:0] d);
      DataAdr = BASE | 16'(o); writeData = d; memwrite = 1'b1;
      cyc();
      memwrite = 1'b0; DataAdr = 16'h0010;
   endtask

   task automatic rd(input logic [3:0] o, input logic [15:0] exp, input string tag);
      DataAdr = BASE | 16'(o);
      #1;
      chk(tag, readData, exp);
   endtask

   task automatic chk_all(input string tag);
      #1;
      chk({tag, ":sel"}, 16'(sel), 16'(DataAdr[15:4] == BASE_HI));
      chk({tag, ":rdata"}, readData, m_rd(DataAdr));
      chk({tag, ":valid"}, 16'(out_valid), 16'(m_q.size() != 0));
      chk({tag, ":odata"}, out_data, (m_q.size() != 0) ? m_q[0] : 16'h0000);
      chk({tag, ":irq"}, 16'(irq), 16'(m_irq));
   endtask

   initial begin
      logic [3:0] o;
      reset = 1'b0; memwrite = 1'b0; out_ready = 1'b0;
      DataAdr = 16'h0010; writeData = 16'h0000;
      model_reset();

      // Reset state
      #1;
      chk("rst_sel", 16'(sel), 16'h0000);
      chk("rst_rdata_out", readData, 16'h0000);
      @(negedge clk); @(negedge clk);
      chk("rst_irq", 16'(irq), 16'h0000);
      chk("rst_valid", 16'(out_valid), 16'h0000);
      reset = 1'b1;
      cyc();
      rd(4'h1, 16'hFFFF, "rst_cmp");
      rd(4'h3, 16'h0010, "rst_status");

      // Counter and compare
      wr(4'h1, 16'h0005);
      wr(4'h4, 16'h0003);
      wr(4'h0, 16'h0000);
      for (int i = 0; i <= 5; i++) begin
         rd(4'h0, 16'(i), "cnt_seq");
         if (i < 5) cyc();
      end
      cyc();
      chk("irq_edge1", 16'(irq), 16'h0000);
      cyc();
      chk("irq_edge2", 16'(irq), 16'h0001);
      rd(4'h3, 16'h0090, "match_status");
      wr(4'h3, 16'h0080);
      chk("irq_hold", 16'(irq), 16'h0001);
      cyc();
      chk("irq_clr", 16'(irq), 16'h0000);
      rd(4'h3, 16'h0010, "match_cleared");

      // Counter wrap
      wr(4'h0, 16'hFFFE);
      rd(4'h0, 16'hFFFE, "wrap0"); cyc();
      rd(4'h0, 16'hFFFF, "wrap1"); cyc();
      rd(4'h0, 16'h0000, "wrap2"); cyc();
      rd(4'h0, 16'h0001, "wrap3");
      wr(4'h4, 16'h0000);

      // FIFO fill and overflow
      out_ready = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         wr(4'h2, 16'(i * 'h1111));
         if (i == 1) begin
            chk("push_valid", 16'(out_valid), 16'h0001);
            chk("push_head", out_data, 16'h1111);
         end
      end
      rd(4'h3, 16'h0028, "fifo_full");
      wr(4'h2, 16'h9999);
      rd(4'h3, 16'h0068, "fifo_ovf");
      chk("ovf_head", out_data, 16'h1111);
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         #1;
         chk("drain", out_data, 16'(i * 'h1111));
         cyc();
      end
      chk("drained_valid", 16'(out_valid), 16'h0000);
      chk("drained_data", out_data, 16'h0000);
      out_ready = 1'b0;
      rd(4'h3, 16'h0050, "ovf_sticky");
      wr(4'h3, 16'h0040);
      rd(4'h3, 16'h0010, "ovf_cleared");

      // Full push+pop in one cycle
      for (int i = 1; i <= 8; i++) wr(4'h2, 16'(i * 'h0101));
      DataAdr = BASE | 16'h0002; writeData = 16'hAAAA; memwrite = 1'b1; out_ready = 1'b1;
      cyc();
      memwrite = 1'b0; out_ready = 1'b0;
      rd(4'h3, 16'h0028, "pushpop_status");
      out_ready = 1'b1;
      for (int i = 2; i <= 8; i++) begin
         #1;
         chk("pp_drain", out_data, 16'(i * 'h0101));
         cyc();
      end
      #1;
      chk("pp_last", out_data, 16'hAAAA);
      cyc();
      chk("pp_empty", 16'(out_valid), 16'h0000);
      out_ready = 1'b0;
      chk_all("post_dir");

      // Randomized traffic against the model
      wr(4'h1, 16'h0008);
      wr(4'h4, 16'h0003);
      for (int n = 0; n < 400; n++) begin
         if (n % 40 == 0) o = 4'($urandom_range(0, 3));
         out_ready = ($urandom_range(0, 3) < int'(o));
         memwrite  = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 9) < 5) DataAdr = BASE | 16'h0002;
         else                          DataAdr = BASE | 16'($urandom_range(0, 7));
         if ($urandom_range(0, 19) == 0) DataAdr = 16'h00F2;
         writeData = 16'($urandom);
         if (DataAdr[3:0] <= 4'h1) writeData = 16'($urandom_range(0, 15));
         chk_all("rand");
         cyc();
      end
      memwrite = 1'b0; out_ready = 1'b1;
      repeat (20) cyc();
      out_ready = 1'b0;
      chk_all("rand_drain");

      // Async reset mid-operation
      wr(4'h4, 16'h0001);
      wr(4'h2, 16'h1234);
      wr(4'h2, 16'h5678);
      wr(4'h2, 16'h9ABC);
      cyc();
      chk_all("pre_areset");
      reset = 1'b0;
      #1;
      model_reset();
      chk("areset_valid", 16'(out_valid), 16'h0000);
      rd(4'h0, 16'h0000, "areset_cycle");
      rd(4'h3, 16'h0010, "areset_status");
      chk("areset_irq", 16'(irq), 16'h0000);
      reset = 1'b1;
      cyc();
      chk_all("post_areset");
      rd(4'h0, 16'h0000, "post_areset_cycle");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
